// File: rtl/rf_ctrl_pkg.sv
// Shared definitions for the register-file access controller.
//   RF_DEPTH    : number of register-file entries
//   RF_ADDR_W   : register-file address width
//   rf_addr_t   : register-file address type
//   addr_conflict(a, b, en_a, en_b) : both ports enabled on the same entry
package rf_ctrl_pkg;

  localparam int RF_DEPTH  = 32;
  localparam int RF_ADDR_W = $clog2(RF_DEPTH);

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  function automatic logic addr_conflict(input rf_addr_t a, input rf_addr_t b,
                                         input logic en_a, input logic en_b);
    return en_a && en_b && (a == b);
  endfunction

endpackage

// File: rtl/rf_access_ctrl_rd_slot.sv
// Single-entry read response register with valid/ready drain.
//   i_clk, i_resetn      : clock, synchronous active-low reset
//   i_load, i_load_data  : capture new read data at the edge
//   i_rsp_ready          : consumer accepts the held response
//   o_rsp_valid/o_rsp_data : registered response
//   o_slot_open          : slot is empty or is being drained this cycle
module rf_rd_slot #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_slot_open
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;

  // A load wins over a drain so a same-cycle drain+refill keeps valid high.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_slot_open = !r_valid || i_rsp_ready;
  assign o_rsp_valid = r_valid;
  assign o_rsp_data  = r_data;

endmodule

// File: rtl/rf_access_ctrl.sv
// Initiator for a 32-entry 1W/2R register file. Arbitrates one write channel
// and two read-request channels so the register file never sees a collision,
// returning read data through registered response slots.
//   i_clk, i_resetn                : clock, synchronous active-low reset
//   i_wr_*, o_wr_ready             : write request channel
//   i_rda_*/o_rda_* , i_rdb_*/o_rdb_* : read request + response channels
//   o_rf_*, i_rf_dout1/2           : register-file port (combinational read)
//   i_rf_collision                 : registered collision flag from the RF
//   o_proto_err                    : sticky collision seen
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 2
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  rf_addr_t              i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rda_req_valid,
  output logic                  o_rda_req_ready,
  input  rf_addr_t              i_rda_addr,
  output logic                  o_rda_rsp_valid,
  input  logic                  i_rda_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rda_rsp_data,
  input  logic                  i_rdb_req_valid,
  output logic                  o_rdb_req_ready,
  input  rf_addr_t              i_rdb_addr,
  output logic                  o_rdb_rsp_valid,
  input  logic                  i_rdb_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rdb_rsp_data,
  output logic [DATA_WIDTH-1:0] o_rf_din,
  output rf_addr_t              o_rf_wad,
  output logic                  o_rf_wen,
  output rf_addr_t              o_rf_rad1,
  output rf_addr_t              o_rf_rad2,
  output logic                  o_rf_ren1,
  output logic                  o_rf_ren2,
  input  logic [DATA_WIDTH-1:0] i_rf_dout1,
  input  logic [DATA_WIDTH-1:0] i_rf_dout2,
  input  logic                  i_rf_collision,
  output logic                  o_proto_err
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_blk_a, r_blk_b;
  logic             r_proto_err;

  logic w_open_a, w_open_b;
  logic w_conf_a, w_conf_b;
  logic w_starve_a, w_starve_b;
  logic w_wr_ready, w_wr_acc;
  logic w_rda_ready, w_rdb_ready;
  logic w_acc_a, w_acc_b;
  logic w_same_rd;
  logic [DATA_WIDTH-1:0] w_load_b_data;

  assign w_conf_a   = addr_conflict(i_wr_addr, i_rda_addr, i_wr_valid, i_rda_req_valid) && w_open_a;
  assign w_conf_b   = addr_conflict(i_wr_addr, i_rdb_addr, i_wr_valid, i_rdb_req_valid) && w_open_b;
  assign w_starve_a = (r_blk_a == LIMIT);
  assign w_starve_b = (r_blk_b == LIMIT);

  // Write goes first unless a reader that has waited long enough wants the
  // same entry; then the write yields for one cycle.
  assign w_wr_ready = i_resetn && !((w_starve_a && w_conf_a) || (w_starve_b && w_conf_b));
  assign w_wr_acc   = i_wr_valid && w_wr_ready;

  assign w_rda_ready = i_resetn && w_open_a && !addr_conflict(i_wr_addr, i_rda_addr, w_wr_acc, 1'b1);
  assign w_rdb_ready = i_resetn && w_open_b && !addr_conflict(i_wr_addr, i_rdb_addr, w_wr_acc, 1'b1);
  assign w_acc_a     = i_rda_req_valid && w_rda_ready;
  assign w_acc_b     = i_rdb_req_valid && w_rdb_ready;

  // Same-address dual read uses port 1 only so the RF never sees rad1==rad2.
  assign w_same_rd     = addr_conflict(i_rda_addr, i_rdb_addr, w_acc_a, w_acc_b);
  assign w_load_b_data = w_same_rd ? i_rf_dout1 : i_rf_dout2;

  assign o_wr_ready      = w_wr_ready;
  assign o_rda_req_ready = w_rda_ready;
  assign o_rdb_req_ready = w_rdb_ready;

  assign o_rf_wen  = w_wr_acc;
  assign o_rf_wad  = w_wr_acc ? i_wr_addr : '0;
  assign o_rf_din  = w_wr_acc ? i_wr_data : '0;
  assign o_rf_ren1 = w_acc_a;
  assign o_rf_rad1 = w_acc_a ? i_rda_addr : '0;
  assign o_rf_ren2 = w_acc_b && !w_same_rd;
  assign o_rf_rad2 = (w_acc_b && !w_same_rd) ? i_rdb_addr : '0;

  rf_rd_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_a (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_load      (w_acc_a),
    .i_load_data (i_rf_dout1),
    .i_rsp_ready (i_rda_rsp_ready),
    .o_rsp_valid (o_rda_rsp_valid),
    .o_rsp_data  (o_rda_rsp_data),
    .o_slot_open (w_open_a)
  );

  rf_rd_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot_b (
    .i_clk       (i_clk),
    .i_resetn    (i_resetn),
    .i_load      (w_acc_b),
    .i_load_data (w_load_b_data),
    .i_rsp_ready (i_rdb_rsp_ready),
    .o_rsp_valid (o_rdb_rsp_valid),
    .o_rsp_data  (o_rdb_rsp_data),
    .o_slot_open (w_open_b)
  );

  // Blocked-cycle counters saturate at the limit; any idle or accepted cycle
  // restarts the wait.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_blk_a     <= '0;
      r_blk_b     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (!i_rda_req_valid || w_acc_a) r_blk_a <= '0;
      else if (w_conf_a && !w_starve_a) r_blk_a <= r_blk_a + CNT_W'(1);

      if (!i_rdb_req_valid || w_acc_b) r_blk_b <= '0;
      else if (w_conf_b && !w_starve_b) r_blk_b <= r_blk_b + CNT_W'(1);

      if (i_rf_collision) r_proto_err <= 1'b1;
    end
  end

  assign o_proto_err = r_proto_err;

endmodule

// File: tb/tb_rf_access_ctrl.sv
module tb_rf_access_ctrl;

  localparam int DW = 16;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [4:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rda_req_valid = 1'b0, rda_req_ready;
  logic [4:0]    rda_addr = '0;
  logic          rda_rsp_valid, rda_rsp_ready = 1'b1;
  logic [DW-1:0] rda_rsp_data;
  logic          rdb_req_valid = 1'b0, rdb_req_ready;
  logic [4:0]    rdb_addr = '0;
  logic          rdb_rsp_valid, rdb_rsp_ready = 1'b1;
  logic [DW-1:0] rdb_rsp_data;
  logic [DW-1:0] rf_din, rf_dout1, rf_dout2;
  logic [4:0]    rf_wad, rf_rad1, rf_rad2;
  logic          rf_wen, rf_ren1, rf_ren2;
  logic          rf_collision = 1'b0;
  logic          force_coll = 1'b0;
  logic          proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_access_ctrl #(.DATA_WIDTH(DW), .STARVE_LIMIT(L)) dut (
    .i_clk(clk), .i_resetn(resetn),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rda_req_valid(rda_req_valid), .o_rda_req_ready(rda_req_ready), .i_rda_addr(rda_addr),
    .o_rda_rsp_valid(rda_rsp_valid), .i_rda_rsp_ready(rda_rsp_ready), .o_rda_rsp_data(rda_rsp_data),
    .i_rdb_req_valid(rdb_req_valid), .o_rdb_req_ready(rdb_req_ready), .i_rdb_addr(rdb_addr),
    .o_rdb_rsp_valid(rdb_rsp_valid), .i_rdb_rsp_ready(rdb_rsp_ready), .o_rdb_rsp_data(rdb_rsp_data),
    .o_rf_din(rf_din), .o_rf_wad(rf_wad), .o_rf_wen(rf_wen),
    .o_rf_rad1(rf_rad1), .o_rf_rad2(rf_rad2), .o_rf_ren1(rf_ren1), .o_rf_ren2(rf_ren2),
    .i_rf_dout1(rf_dout1), .i_rf_dout2(rf_dout2), .i_rf_collision(rf_collision),
    .o_proto_err(proto_err)
  );

  // Register file: combinational reads, registered write and collision flag.
  logic [DW-1:0] mem [32] = '{default: '0};
  assign rf_dout1 = mem[rf_rad1];
  assign rf_dout2 = mem[rf_rad2];
  always @(posedge clk) begin
    if (rf_wen) mem[rf_wad] <= rf_din;
    rf_collision <= force_coll ||
                    (rf_wen && rf_ren1 && rf_wad == rf_rad1) ||
                    (rf_wen && rf_ren2 && rf_wad == rf_rad2) ||
                    (rf_ren1 && rf_ren2 && rf_rad1 == rf_rad2);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory contents as seen by accepted writes, expected
  // responses per channel, blocked-cycle counts.
  logic [DW-1:0] ref_mem [32] = '{default: '0};
  logic [DW-1:0] qa[$], qb[$];
  int  blk_a = 0, blk_b = 0;
  logic exp_proto = 1'b0;
  logic rst_prev = 1'b0;

  always @(posedge clk) exp_proto <= !resetn ? 1'b0 : (exp_proto | rf_collision);

  always @(negedge clk) begin
    logic open_a, open_b, wacc, acc_a, acc_b, conf_a, conf_b, exp_wr, same;
    if (!resetn) begin
      chk("rst_ready_gating", 32'({wr_ready, rda_req_ready, rdb_req_ready, rf_wen, rf_ren1, rf_ren2}), 32'd0);
      if (rst_prev) begin
        chk("rst_rsp_valid_proto", 32'({rda_rsp_valid, rdb_rsp_valid, proto_err}), 32'd0);
        chk("rst_rsp_data", {rda_rsp_data, rdb_rsp_data}, 32'd0);
      end
      qa.delete(); qb.delete();
      blk_a = 0; blk_b = 0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      open_a = !rda_rsp_valid || rda_rsp_ready;
      open_b = !rdb_rsp_valid || rdb_rsp_ready;
      conf_a = wr_valid && rda_req_valid && open_a && wr_addr == rda_addr;
      conf_b = wr_valid && rdb_req_valid && open_b && wr_addr == rdb_addr;
      exp_wr = !((blk_a == L && conf_a) || (blk_b == L && conf_b));
      chk("wr_ready", 32'(wr_ready), 32'(exp_wr));
      wacc = wr_valid && exp_wr;
      chk("rda_req_ready", 32'(rda_req_ready), 32'(open_a && !(wacc && wr_addr == rda_addr)));
      chk("rdb_req_ready", 32'(rdb_req_ready), 32'(open_b && !(wacc && wr_addr == rdb_addr)));
      acc_a = rda_req_valid && rda_req_ready;
      acc_b = rdb_req_valid && rdb_req_ready;
      same  = acc_a && acc_b && rda_addr == rdb_addr;

      chk("rf_enables", 32'({rf_wen, rf_ren1, rf_ren2}), 32'({wacc, acc_a, acc_b && !same}));
      chk("rf_wr_port", {11'd0, rf_wad, rf_din}, wacc ? {11'd0, wr_addr, wr_data} : 32'd0);
      chk("rf_rd_addr", 32'({rf_rad1, rf_rad2}),
          32'({acc_a ? rda_addr : 5'd0, (acc_b && !same) ? rdb_addr : 5'd0}));
      chk("no_rf_collision", 32'({rf_wen && rf_ren1 && rf_wad == rf_rad1,
                                  rf_wen && rf_ren2 && rf_wad == rf_rad2,
                                  rf_ren1 && rf_ren2 && rf_rad1 == rf_rad2}), 32'd0);
      chk("proto_err", 32'(proto_err), 32'(exp_proto));

      chk("rda_rsp_valid", 32'(rda_rsp_valid), 32'(qa.size() != 0));
      if (rda_rsp_valid && qa.size() != 0) begin
        chk("rda_rsp_data", 32'(rda_rsp_data), 32'(qa[0]));
        if (rda_rsp_ready) void'(qa.pop_front());
      end
      chk("rdb_rsp_valid", 32'(rdb_rsp_valid), 32'(qb.size() != 0));
      if (rdb_rsp_valid && qb.size() != 0) begin
        chk("rdb_rsp_data", 32'(rdb_rsp_data), 32'(qb[0]));
        if (rdb_rsp_ready) void'(qb.pop_front());
      end

      // Reads see memory before this cycle's write.
      if (acc_a) qa.push_back(ref_mem[rda_addr]);
      if (acc_b) qb.push_back(ref_mem[rdb_addr]);
      if (wacc) ref_mem[wr_addr] = wr_data;

      if (!rda_req_valid || acc_a) blk_a = 0;
      else if (conf_a && blk_a < L) blk_a++;
      if (!rdb_req_valid || acc_b) blk_b = 0;
      else if (conf_b && blk_b < L) blk_b++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w_done, a_done, b_done;
    resetn = 1'b0;
    repeat (3) step();
    mid();
    chk("reset_rsp_valid", 32'({rda_rsp_valid, rdb_rsp_valid}), 32'd0);
    chk("reset_proto", 32'(proto_err), 32'd0);
    step(); resetn = 1'b1;

    // write then read back
    wr_valid = 1'b1; wr_addr = 5'd5; wr_data = 16'h1234;
    mid(); chk("t1_wr_ready", 32'(wr_ready), 32'd1);
    step(); wr_valid = 1'b0; rda_req_valid = 1'b1; rda_addr = 5'd5;
    mid(); chk("t1_rda_req_ready", 32'(rda_req_ready), 32'd1);
    step(); rda_req_valid = 1'b0;
    mid(); chk("t1_rsp", 32'({rda_rsp_valid, rda_rsp_data}), 32'({1'b1, 16'h1234}));
    chk("t1_proto", 32'(proto_err), 32'd0);

    // same-cycle write and read to address 7
    step(); wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 16'hBEEF; rda_req_valid = 1'b1; rda_addr = 5'd7;
    mid(); chk("t2_wr_ready", 32'(wr_ready), 32'd1); chk("t2_rda_blocked", 32'(rda_req_ready), 32'd0);
    step(); wr_valid = 1'b0;
    mid(); chk("t2_rda_accept", 32'(rda_req_ready), 32'd1);
    step(); rda_req_valid = 1'b0;
    mid(); chk("t2_rsp", 32'({rda_rsp_valid, rda_rsp_data}), 32'({1'b1, 16'hBEEF}));
    chk("t2_proto", 32'(proto_err), 32'd0);

    // dual read of the same address
    step(); wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 16'h00AA;
    step(); wr_valid = 1'b0; rda_req_valid = 1'b1; rda_addr = 5'd3; rdb_req_valid = 1'b1; rdb_addr = 5'd3;
    mid(); chk("t3_ren", 32'({rf_ren1, rf_ren2, rf_rad1}), 32'({1'b1, 1'b0, 5'd3}));
    step(); rda_req_valid = 1'b0; rdb_req_valid = 1'b0;
    mid(); chk("t3_rsp_a", 32'({rda_rsp_valid, rda_rsp_data}), 32'({1'b1, 16'h00AA}));
    chk("t3_rsp_b", 32'({rdb_rsp_valid, rdb_rsp_data}), 32'({1'b1, 16'h00AA}));

    // starvation of read B against a persistent writer
    step(); wr_valid = 1'b1; wr_addr = 5'd9; wr_data = 16'h9999; rdb_req_valid = 1'b1; rdb_addr = 5'd9;
    mid(); chk("t4_c1", 32'({wr_ready, rdb_req_ready}), 32'b10);
    step();
    mid(); chk("t4_c2", 32'({wr_ready, rdb_req_ready}), 32'b10);
    step();
    mid(); chk("t4_c3", 32'({wr_ready, rdb_req_ready}), 32'b01);
    step(); rdb_req_valid = 1'b0;
    mid(); chk("t4_rsp", 32'({rdb_rsp_valid, rdb_rsp_data}), 32'({1'b1, 16'h9999}));
    chk("t4_wr_resumes", 32'(wr_ready), 32'd1);
    step(); wr_valid = 1'b0;

    // backpressure then back-to-back refill
    rda_rsp_ready = 1'b0; rda_req_valid = 1'b1; rda_addr = 5'd5;
    mid(); chk("t5_first_accept", 32'(rda_req_ready), 32'd1);
    step(); rda_addr = 5'd3;
    mid(); chk("t5_held1", 32'({rda_req_ready, rda_rsp_valid, rda_rsp_data}), 32'({2'b01, 16'h1234}));
    step();
    mid(); chk("t5_held2", 32'({rda_req_ready, rda_rsp_valid, rda_rsp_data}), 32'({2'b01, 16'h1234}));
    step(); rda_rsp_ready = 1'b1;
    mid(); chk("t5_release", 32'({rda_req_ready, rda_rsp_valid, rda_rsp_data}), 32'({2'b11, 16'h1234}));
    step(); rda_addr = 5'd5;
    mid(); chk("t5_refill1", 32'({rda_req_ready, rda_rsp_valid, rda_rsp_data}), 32'({2'b11, 16'h00AA}));
    step(); rda_req_valid = 1'b0;
    mid(); chk("t5_refill2", 32'({rda_rsp_valid, rda_rsp_data}), 32'({1'b1, 16'h1234}));
    step();
    mid(); chk("t5_empty", 32'(rda_rsp_valid), 32'd0);

    // randomized traffic with held requests and random backpressure
    for (int i = 0; i < 3000; i++) begin
      mid();
      w_done = wr_valid && wr_ready;
      a_done = rda_req_valid && rda_req_ready;
      b_done = rdb_req_valid && rdb_req_ready;
      step();
      if (!wr_valid || w_done) begin
        wr_valid = ($urandom_range(0, 99) < 60);
        wr_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
        wr_data  = 16'($urandom);
      end
      if (!rda_req_valid || a_done) begin
        rda_req_valid = ($urandom_range(0, 99) < 60);
        rda_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      end
      if (!rdb_req_valid || b_done) begin
        rdb_req_valid = ($urandom_range(0, 99) < 60);
        rdb_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      end
      rda_rsp_ready = ($urandom_range(0, 3) != 0);
      rdb_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    wr_valid = 1'b0; rda_req_valid = 1'b0; rdb_req_valid = 1'b0;
    rda_rsp_ready = 1'b1; rdb_rsp_ready = 1'b1;
    repeat (4) step();

    // injected collision sets a sticky error
    force_coll = 1'b1;
    step(); force_coll = 1'b0;
    mid(); chk("t6_proto_pre", 32'(proto_err), 32'd0);
    step();
    mid(); chk("t6_proto_set", 32'(proto_err), 32'd1);
    repeat (5) step();
    mid(); chk("t6_proto_sticky", 32'(proto_err), 32'd1);

    // reset with responses pending
    step(); rda_rsp_ready = 1'b0; rdb_rsp_ready = 1'b0;
    rda_req_valid = 1'b1; rda_addr = 5'd1; rdb_req_valid = 1'b1; rdb_addr = 5'd2;
    step(); rda_req_valid = 1'b0; rdb_req_valid = 1'b0;
    mid(); chk("t7_pending", 32'({rda_rsp_valid, rdb_rsp_valid}), 32'b11);
    step(); resetn = 1'b0; rda_rsp_ready = 1'b1; rdb_rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 16'h0001; rda_req_valid = 1'b1; rda_addr = 5'd6;
    mid(); chk("t7_ready_gated", 32'({wr_ready, rda_req_ready, rdb_req_ready, rf_wen, rf_ren1}), 32'd0);
    step();
    mid(); chk("t7_rsp_cleared", 32'({rda_rsp_valid, rdb_rsp_valid, proto_err}), 32'd0);
    step(); resetn = 1'b1; wr_valid = 1'b0; rda_req_valid = 1'b0;
    mid(); chk("t7_no_replay", 32'({rda_rsp_valid, rdb_rsp_valid}), 32'd0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
